// File: rtl/lisnoc16_usb_tx_arbiter.sv
// Round-robin arbiter sharing one 16-bit USB transmit stream between several
// debug-NoC converters; a grant is held for one complete length-prefixed frame.
//
// state   | meaning
// IDLE    | no owner; pick the next requester searching from last_grant+1
// HEADER  | owner's length header is forwarded (optionally tagged with port index)
// PAYLOAD | owner's payload words are forwarded until remaining reaches zero
module lisnoc16_usb_tx_arbiter #(
  parameter int PORTS      = 2,
  parameter int PORT_WIDTH = 1,
  parameter int MAX_LEN    = 32,
  parameter bit TAG_ENABLE = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [16*PORTS-1:0]   in_usb_data,
  input  logic [PORTS-1:0]      in_usb_valid,
  output logic [PORTS-1:0]      in_usb_ready,
  output logic [15:0]           out_usb_data,
  output logic                  out_usb_valid,
  input  logic                  out_usb_ready,
  output logic [PORTS-1:0]      grant,
  output logic                  busy,
  output logic                  err_len
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HEADER  = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;

  // The length field is 6 bits, so a limit above 63 can never be exceeded.
  localparam logic [5:0] MAX_LEN_W = 6'((MAX_LEN > 63) ? 63 : MAX_LEN);
  localparam logic [PORT_WIDTH-1:0] LAST_RST = PORT_WIDTH'(PORTS - 1);

  logic [1:0]            state_q, state_d;
  logic [PORTS-1:0]      grant_q, grant_d;
  logic [PORT_WIDTH-1:0] gidx_q, gidx_d;
  logic [PORT_WIDTH-1:0] last_q, last_d;
  logic [5:0]            rem_q, rem_d;
  logic                  err_q, err_d;

  logic                  pick_found;
  logic [PORT_WIDTH-1:0] pick_idx;
  logic [15:0]           sel_data;
  logic                  sel_valid;
  logic                  active;
  logic                  hs;
  logic [5:0]            hdr_len;

  // Two passes give wrap-around priority: ports above last_grant first.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (!pick_found && (p > int'(last_q)) && in_usb_valid[p]) begin
        pick_found = 1'b1;
        pick_idx   = PORT_WIDTH'(p);
      end
    end
    for (int p = 0; p < PORTS; p++) begin
      if (!pick_found && (p <= int'(last_q)) && in_usb_valid[p]) begin
        pick_found = 1'b1;
        pick_idx   = PORT_WIDTH'(p);
      end
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    for (int p = 0; p < PORTS; p++) begin
      if (gidx_q == PORT_WIDTH'(p)) begin
        sel_data  = in_usb_data[16*p +: 16];
        sel_valid = in_usb_valid[p];
      end
    end
  end

  assign active  = (state_q != ST_IDLE);
  assign hs      = active && sel_valid && out_usb_ready;
  assign hdr_len = sel_data[5:0];

  always_comb begin
    out_usb_data = '0;
    if (active) begin
      out_usb_data = sel_data;
      if (TAG_ENABLE && (state_q == ST_HEADER)) begin
        out_usb_data[15:12] = 4'(gidx_q);
      end
    end
  end

  assign out_usb_valid = active && sel_valid;
  assign in_usb_ready  = out_usb_ready ? grant_q : '0;
  assign grant         = grant_q;
  assign busy          = active;
  assign err_len       = err_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    rem_d   = rem_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          gidx_d            = pick_idx;
          last_d            = pick_idx;
          state_d           = ST_HEADER;
        end
      end
      ST_HEADER: begin
        if (hs) begin
          if (hdr_len > MAX_LEN_W) begin
            err_d = 1'b1;
            rem_d = MAX_LEN_W;
          end else begin
            rem_d = hdr_len;
          end
          if (hdr_len == 6'd0) begin
            state_d = ST_IDLE;
            grant_d = '0;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (hs) begin
          rem_d = rem_q - 6'd1;
          if (rem_q == 6'd1) begin
            state_d = ST_IDLE;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= LAST_RST;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

endmodule
